// File: rtl/revo_word_sequencer.sv
// Revolution-marker word generator for a serializer, free-running or locked to an external sync.
// Optional fine bit-phase shaping of the marker edges is enabled with the REVO_FINE_PHASE_EN macro.
module revo_word_sequencer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned COUNTER_WIDTH = 11
) (
  input  logic                         clock50,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         sync_mode,
  input  logic                         sync_in,
  input  logic [COUNTER_WIDTH-1:0]     period_minus_one,
  input  logic [COUNTER_WIDTH-1:0]     pulse_length,
  input  logic [$clog2(WIDTH)-1:0]     fine_phase,
  input  logic                         clear_error,
  output logic [WIDTH-1:0]             revo_word,
  output logic [WIDTH-1:0]             clock_word,
  output logic                         revo_strobe,
  output logic                         locked,
  output logic                         sync_error,
  output logic [7:0]                   mismatch_count
);

  localparam int unsigned PHASE_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] CLOCK_PATTERN = {(WIDTH/2){2'b10}};
  localparam logic [WIDTH-1:0] ALL_ONES      = {WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, FREE, ARMED, LOCKED} state_t;

  state_t                   state, state_nxt;
  logic [COUNTER_WIDTH-1:0] position, position_nxt;
  logic [COUNTER_WIDTH-1:0] period_active, period_nxt;
  logic                     sync_q;
  logic                     sync_edge;
  logic                     misalign;
  logic                     running;
  logic [PHASE_W-1:0]       phase;
  logic [WIDTH-1:0]         word_nxt;

`ifdef REVO_FINE_PHASE_EN
  assign phase = fine_phase;
`else
  logic unused_fine_phase;
  assign unused_fine_phase = ^fine_phase;
  assign phase = '0;
`endif

  assign sync_edge = sync_in & ~sync_q;
  assign running   = (state == FREE) || (state == LOCKED);

  // State, position and period register
  always_ff @(posedge clock50) begin
    if (reset) begin
      state         <= IDLE;
      position      <= '0;
      period_active <= '0;
      sync_q        <= 1'b0;
    end else begin
      state         <= state_nxt;
      position      <= position_nxt;
      period_active <= period_nxt;
      sync_q        <= sync_in;
    end
  end

  // Next-state, position advance and alignment check
  always_comb begin
    state_nxt    = state;
    position_nxt = position;
    period_nxt   = period_active;
    misalign     = 1'b0;
    case (state)
      IDLE: begin
        state_nxt    = sync_mode ? ARMED : FREE;
        position_nxt = '0;
        period_nxt   = period_minus_one;
      end
      FREE: begin
        if (sync_mode) begin
          state_nxt    = ARMED;
          position_nxt = '0;
          period_nxt   = period_minus_one;
        end else if (position >= period_active) begin
          position_nxt = '0;
          period_nxt   = period_minus_one;
        end else begin
          position_nxt = position + COUNTER_WIDTH'(1);
        end
      end
      ARMED: begin
        position_nxt = '0;
        if (!sync_mode) begin
          state_nxt  = FREE;
          period_nxt = period_minus_one;
        end else if (sync_edge) begin
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (!sync_mode) begin
          state_nxt    = FREE;
          position_nxt = '0;
          period_nxt   = period_minus_one;
        end else if (sync_edge && (position != period_active)) begin
          misalign     = 1'b1;
          position_nxt = '0;
        end else if (position >= period_active) begin
          position_nxt = '0;
          period_nxt   = period_minus_one;
        end else begin
          position_nxt = position + COUNTER_WIDTH'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable) begin
      state_nxt    = IDLE;
      position_nxt = '0;
      misalign     = 1'b0;
    end
  end

  // Marker word for the current position; an oversized pulse saturates to all-ones
  always_comb begin
    word_nxt = '0;
    if (running && (pulse_length != '0)) begin
      if (pulse_length > period_active) begin
        word_nxt = ALL_ONES;
      end else if (position == '0) begin
        word_nxt = ALL_ONES >> phase;
      end else if (position < pulse_length) begin
        word_nxt = ALL_ONES;
      end else if (position == pulse_length) begin
        word_nxt = ~(ALL_ONES >> phase);
      end
    end
  end

  // Registered word outputs, cleared immediately when enable drops
  always_ff @(posedge clock50) begin
    if (reset || !enable) begin
      revo_word   <= '0;
      clock_word  <= '0;
      revo_strobe <= 1'b0;
      locked      <= 1'b0;
    end else begin
      revo_word   <= word_nxt;
      clock_word  <= (state != IDLE) ? CLOCK_PATTERN : '0;
      revo_strobe <= running && (position == '0) && (pulse_length != '0);
      locked      <= (state_nxt == LOCKED);
    end
  end

  // Sticky error and saturating mismatch counter; a fresh misalignment beats clear_error
  always_ff @(posedge clock50) begin
    if (reset) begin
      sync_error     <= 1'b0;
      mismatch_count <= '0;
    end else if (misalign) begin
      sync_error     <= 1'b1;
      if (clear_error)
        mismatch_count <= 8'd1;
      else if (mismatch_count != 8'hFF)
        mismatch_count <= mismatch_count + 8'd1;
    end else if (clear_error) begin
      sync_error     <= 1'b0;
      mismatch_count <= '0;
    end
  end

endmodule

// File: tb/tb_revo_word_sequencer.sv
// Self-checking bench for revo_word_sequencer: directed scenarios plus random stimulus
// compared every cycle against a bit-stream reference model.
module tb_revo_word_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = 11;
  localparam int M_IDLE = 0, M_FREE = 1, M_ARMED = 2, M_LOCKED = 3;

  logic          clock50 = 1'b0;
  logic          reset = 1'b1, enable = 1'b0, sync_mode = 1'b0, sync_in = 1'b0, clear_error = 1'b0;
  logic [CW-1:0] period_minus_one = '0, pulse_length = '0;
  logic [2:0]    fine_phase = '0;
  logic [7:0]    revo_word, clock_word, mismatch_count;
  logic          revo_strobe, locked, sync_error;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int         m_mode = M_IDLE, m_pos = 0, m_per = 0, m_cnt = 0;
  bit         m_sq = 0, m_err = 0;
  logic [7:0] e_revo = '0, e_clk = '0;
  bit         e_stb = 0, e_lock = 0;

  revo_word_sequencer #(.WIDTH(WIDTH), .COUNTER_WIDTH(CW)) dut (
    .clock50(clock50), .reset(reset), .enable(enable), .sync_mode(sync_mode),
    .sync_in(sync_in), .period_minus_one(period_minus_one), .pulse_length(pulse_length),
    .fine_phase(fine_phase), .clear_error(clear_error), .revo_word(revo_word),
    .clock_word(clock_word), .revo_strobe(revo_strobe), .locked(locked),
    .sync_error(sync_error), .mismatch_count(mismatch_count)
  );

  always #10 clock50 = ~clock50;

  // One revolution is a bit stream of (per+1)*8 bits; the marker covers bits [p, p+pl*8), wrapped.
  function automatic logic [7:0] ref_word(int pos, int per, int pl, int p);
    int L;
    int g;
    logic [7:0] w;
    L = (per + 1) * 8;
    w = '0;
    if (pl == 0) return 8'h00;
    if (pl * 8 >= L) return 8'hFF;
    for (int i = 0; i < 8; i++) begin
      g = pos * 8 + i;
      if ((g >= p && g < p + pl * 8) || (g + L >= p && g + L < p + pl * 8)) w[7-i] = 1'b1;
    end
    return w;
  endfunction

  task automatic model_step();
    bit edge_seen, mis, act;
    int nmode, npos, nper, p, pl;
    edge_seen = sync_in && !m_sq;
    if (reset) begin
      m_mode = M_IDLE; m_pos = 0; m_per = 0; m_sq = 0; m_err = 0; m_cnt = 0;
      e_revo = '0; e_clk = '0; e_stb = 0; e_lock = 0;
      return;
    end
`ifdef REVO_FINE_PHASE_EN
    p = int'(fine_phase);
`else
    p = 0;
`endif
    pl  = int'(pulse_length);
    act = (m_mode == M_FREE) || (m_mode == M_LOCKED);
    mis = 0;
    nmode = m_mode; npos = m_pos; nper = m_per;
    if (!enable) begin
      nmode = M_IDLE; npos = 0;
    end else if (m_mode == M_IDLE) begin
      nmode = sync_mode ? M_ARMED : M_FREE; npos = 0; nper = int'(period_minus_one);
    end else if ((m_mode == M_FREE) == sync_mode) begin
      // mode flip between free-running and sync-aligned operation
      nmode = sync_mode ? M_ARMED : M_FREE; npos = 0; nper = int'(period_minus_one);
    end else if (m_mode == M_ARMED) begin
      npos = 0;
      if (edge_seen) nmode = M_LOCKED;
    end else if (m_mode == M_LOCKED && edge_seen && m_pos != m_per) begin
      mis = 1; npos = 0;
    end else if (m_pos >= m_per) begin
      npos = 0; nper = int'(period_minus_one);
    end else begin
      npos = m_pos + 1;
    end
    e_revo = (enable && act) ? ref_word(m_pos, m_per, pl, p) : 8'h00;
    e_clk  = (enable && m_mode != M_IDLE) ? 8'hAA : 8'h00;
    e_stb  = enable && act && m_pos == 0 && pl != 0;
    e_lock = (nmode == M_LOCKED);
    if (mis) begin
      m_err = 1;
      m_cnt = clear_error ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (clear_error) begin
      m_err = 0; m_cnt = 0;
    end
    m_mode = nmode; m_pos = npos; m_per = nper; m_sq = sync_in;
  endtask

  // Advance one clock, update the model, and compare every output just after the edge
  task automatic cycle();
    @(posedge clock50);
    model_step();
    #1;
    n_cmp += 6;
    if (revo_word !== e_revo) begin n_bad++; $display("FAIL revo_word t=%0t got %h want %h", $time, revo_word, e_revo); end
    if (clock_word !== e_clk) begin n_bad++; $display("FAIL clock_word t=%0t got %h want %h", $time, clock_word, e_clk); end
    if (revo_strobe !== e_stb) begin n_bad++; $display("FAIL revo_strobe t=%0t got %b want %b", $time, revo_strobe, e_stb); end
    if (locked !== e_lock) begin n_bad++; $display("FAIL locked t=%0t got %b want %b", $time, locked, e_lock); end
    if (sync_error !== m_err) begin n_bad++; $display("FAIL sync_error t=%0t got %b want %b", $time, sync_error, m_err); end
    if (mismatch_count !== 8'(m_cnt)) begin n_bad++; $display("FAIL mismatch_count t=%0t got %0d want %0d", $time, mismatch_count, m_cnt); end
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b1; sync_in = 1'b1; clear_error = 1'b1; sync_mode = 1'b0;
    period_minus_one = 11'd9; pulse_length = 11'd2;
    do_reset(4);
    sync_in = 1'b0; clear_error = 1'b0;
    n_cmp++;
    if ({revo_word, clock_word, revo_strobe, locked, sync_error, mismatch_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h/%h/%b/%b/%b/%0d want all zero",
               revo_word, clock_word, revo_strobe, locked, sync_error, mismatch_count);
    end
  endtask

  task automatic test_free_run();
    int first = 0, n_ff = 0, n_stb = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (revo_strobe === 1'b1) begin n_stb++; if (first == 0) first = i; end
      if (revo_word === 8'hFF) n_ff++;
    end
    n_cmp += 3;
    if (first != 2) begin n_bad++; $display("FAIL free_first_strobe got edge %0d want 2", first); end
    if (n_stb != 4) begin n_bad++; $display("FAIL free_strobe_count got %0d want 4", n_stb); end
    if (n_ff != 8) begin n_bad++; $display("FAIL free_marker_words got %0d want 8", n_ff); end
  endtask

  task automatic test_lock();
    do_reset(2);
    enable = 1'b1; sync_mode = 1'b1; period_minus_one = 11'd9; pulse_length = 11'd2;
    repeat (6) cycle();
    sync_in = 1'b1; cycle();
    n_cmp++;
    if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_after_edge got %b want 1", locked); end
    sync_in = 1'b0; cycle();
    n_cmp++;
    if (revo_strobe !== 1'b1 || revo_word !== 8'hFF) begin
      n_bad++; $display("FAIL lock_first_marker got %b/%h want 1/ff", revo_strobe, revo_word);
    end
    for (int k = 0; k < 2; k++) begin
      repeat (8) cycle();
      sync_in = 1'b1; cycle();
      sync_in = 1'b0; cycle();
    end
    n_cmp++;
    if (sync_error !== 1'b0 || locked !== 1'b1) begin
      n_bad++; $display("FAIL lock_aligned got err=%b locked=%b want 0/1", sync_error, locked);
    end
  endtask

  task automatic test_misalign();
    repeat (3) cycle();
    sync_in = 1'b1; cycle();
    n_cmp++;
    if (sync_error !== 1'b1 || mismatch_count !== 8'd1) begin
      n_bad++; $display("FAIL misalign_flag got %b/%0d want 1/1", sync_error, mismatch_count);
    end
    sync_in = 1'b0; cycle();
    n_cmp++;
    if (revo_strobe !== 1'b1) begin n_bad++; $display("FAIL misalign_restart got %b want 1", revo_strobe); end
    clear_error = 1'b1; cycle(); clear_error = 1'b0;
    n_cmp++;
    if (sync_error !== 1'b0 || mismatch_count !== 8'd0) begin
      n_bad++; $display("FAIL clear_error got %b/%0d want 0/0", sync_error, mismatch_count);
    end
  endtask

  task automatic test_period_change();
    int s[$];
    do_reset(2);
    enable = 1'b1; sync_mode = 1'b0; period_minus_one = 11'd9; pulse_length = 11'd1;
    for (int i = 1; i <= 30; i++) begin
      if (i == 6) period_minus_one = 11'd4;
      cycle();
      if (revo_strobe === 1'b1) s.push_back(i);
    end
    n_cmp++;
    if (s.size() < 4 || s[0] != 2 || s[1] != 12 || s[2] != 17 || s[3] != 22) begin
      n_bad++;
      $display("FAIL period_change strobes got %p want 2,12,17,22,...", s);
    end
  endtask

  task automatic test_boundaries();
    int bad_zero = 0, bad_ones = 0;
    do_reset(2);
    enable = 1'b1; sync_mode = 1'b0; period_minus_one = 11'd9; pulse_length = 11'd0;
    repeat (20) begin
      cycle();
      if (revo_word !== 8'h00 || revo_strobe !== 1'b0) bad_zero++;
    end
    pulse_length = 11'd20;
    cycle();
    repeat (20) begin
      cycle();
      if (revo_word !== 8'hFF) bad_ones++;
    end
    n_cmp += 2;
    if (bad_zero != 0) begin n_bad++; $display("FAIL pulse_zero got %0d nonzero words want 0", bad_zero); end
    if (bad_ones != 0) begin n_bad++; $display("FAIL pulse_oversize got %0d non-ff words want 0", bad_ones); end
    pulse_length = 11'd5;
    do_reset(1);
    enable = 1'b1;
    repeat (4) cycle();
    enable = 1'b0; cycle();
    n_cmp++;
    if ({revo_word, clock_word, revo_strobe, locked} !== '0) begin
      n_bad++; $display("FAIL enable_drop got %h/%h/%b/%b want all zero", revo_word, clock_word, revo_strobe, locked);
    end
  endtask

  task automatic test_fine_phase();
    logic [7:0] w0, w1;
    int budget = 0;
    do_reset(2);
    enable = 1'b1; sync_mode = 1'b0; period_minus_one = 11'd9; pulse_length = 11'd1; fine_phase = 3'd3;
    cycle();
    while (revo_strobe !== 1'b1 && budget < 20) begin cycle(); budget++; end
    w0 = revo_word;
    cycle();
    w1 = revo_word;
`ifdef REVO_FINE_PHASE_EN
    n_cmp++;
    if (w0 !== 8'h1F || w1 !== 8'hE0) begin n_bad++; $display("FAIL fine_phase got %h,%h want 1f,e0", w0, w1); end
`else
    n_cmp++;
    if (w0 !== 8'hFF || w1 !== 8'h00) begin n_bad++; $display("FAIL fine_phase got %h,%h want ff,00", w0, w1); end
`endif
    fine_phase = 3'd0;
  endtask

  task automatic test_saturation();
    do_reset(2);
    enable = 1'b1; sync_mode = 1'b1; period_minus_one = 11'd9; pulse_length = 11'd2;
    repeat (3) cycle();
    sync_in = 1'b1; cycle(); sync_in = 1'b0; cycle();
    repeat (260) begin
      sync_in = 1'b1; cycle();
      sync_in = 1'b0; cycle();
    end
    n_cmp++;
    if (mismatch_count !== 8'd255 || sync_error !== 1'b1) begin
      n_bad++; $display("FAIL saturate got %0d/%b want 255/1", mismatch_count, sync_error);
    end
    sync_in = 1'b1; clear_error = 1'b1; cycle();
    sync_in = 1'b0; clear_error = 1'b0;
    n_cmp++;
    if (mismatch_count !== 8'd1 || sync_error !== 1'b1) begin
      n_bad++; $display("FAIL clear_vs_misalign got %0d/%b want 1/1", mismatch_count, sync_error);
    end
  endtask

  task automatic test_random();
    do_reset(2);
    for (int i = 0; i < 1500; i++) begin
      reset       = ($urandom_range(63) == 0);
      enable      = ($urandom_range(31) != 0);
      if ($urandom_range(31) == 0) sync_mode = ~sync_mode;
      sync_in     = ($urandom_range(5) == 0);
      clear_error = ($urandom_range(15) == 0);
      if ($urandom_range(7) == 0) period_minus_one = CW'($urandom_range(7));
      if ($urandom_range(7) == 0) pulse_length = CW'($urandom_range(9));
      if ($urandom_range(7) == 0) fine_phase = 3'($urandom_range(7));
      cycle();
    end
    reset = 1'b0; clear_error = 1'b0; sync_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_lock();
    test_misalign();
    test_period_change();
    test_boundaries();
    test_fine_phase();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/revo_word_sequencer.md
REVO_WORD_SEQUENCER -- requirements
Module: revo_word_sequencer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: serializer word width in bits; power of two, at least 2.
REQ-002 The module SHALL have parameter COUNTER_WIDTH, default 11: width of the revolution position counter.
REQ-003 The module SHALL have port clock50, input, 1 bit: the only clock; all logic is rising-edge.
REQ-004 The module SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 The module SHALL have port enable, input, 1 bit: run request.
REQ-006 The module SHALL have port sync_mode, input, 1 bit: 0 = free-running; 1 = align to sync_in.
REQ-007 The module SHALL have port sync_in, input, 1 bit: external revolution marker, already synchronous to clock50.
REQ-008 The module SHALL have port period_minus_one, input, COUNTER_WIDTH bits: revolution length in words, minus one.
REQ-009 The module SHALL have port pulse_length, input, COUNTER_WIDTH bits: marker length in words.
REQ-010 The module SHALL have port fine_phase, input, clog2(WIDTH) bits: marker bit offset within a word.
REQ-011 The module SHALL have port clear_error, input, 1 bit: clears sync_error.
REQ-012 The module SHALL have port revo_word, output, WIDTH bits: marker word; MSB is serialized first.
REQ-013 The module SHALL have port clock_word, output, WIDTH bits: forwarded-clock pattern word.
REQ-014 The module SHALL have port revo_strobe, output, 1 bit: one-cycle pulse on the first marker word.
REQ-015 The module SHALL have port locked, output, 1 bit: high while in state LOCKED.
REQ-016 The module SHALL have port sync_error, output, 1 bit: sticky sync misalignment flag.
REQ-017 The module SHALL have port mismatch_count, output, 8 bits: saturating count of misaligned sync edges.

Function
REQ-018 The block SHALL implement four states: IDLE, FREE, ARMED and LOCKED.
REQ-019 In any state with enable=0, the block SHALL go to IDLE on the next edge.
REQ-020 From IDLE with enable=1, the block SHALL go to FREE if sync_mode=0, else to ARMED; in the same edge, position <= 0.
REQ-021 A change of sync_mode while enabled SHALL take effect as follows: FREE->ARMED when sync_mode=1; ARMED or LOCKED->FREE when sync_mode=0.
REQ-022 In FREE and LOCKED, position SHALL increment each cycle and wrap to 0 after reaching period_active.
REQ-023 In IDLE and ARMED, position SHALL hold at 0.
REQ-024 period_active SHALL load period_minus_one on entry to FREE or ARMED and at each wrap; mid-revolution changes of period_minus_one SHALL have no effect until then.
REQ-025 A sync edge SHALL be defined as sync_in=1 with sync_in registered low on the previous cycle.
REQ-026 A sync edge in ARMED SHALL cause position <= 0 and a transition to LOCKED.
REQ-027 A sync edge in LOCKED with position==period_active SHALL be aligned and SHALL leave behaviour unchanged.
REQ-028 A sync edge in LOCKED with any other position SHALL set sync_error, increment mismatch_count (saturating at 255) and set position <= 0.
REQ-029 Sync edges in IDLE and FREE SHALL be ignored.
REQ-030 clear_error SHALL clear sync_error and mismatch_count on the next edge; a new misalignment in the same cycle SHALL win (sync_error=1, mismatch_count=1).
REQ-031 Outputs SHALL be registered from position with one cycle of latency.
REQ-032 In FREE or LOCKED, revo_word SHALL be all-ones while position < pulse_length and all-zeros otherwise.
REQ-033 pulse_length=0 SHALL produce no marker and no strobe.
REQ-034 pulse_length > period_active SHALL produce continuous all-ones.
REQ-035 revo_strobe SHALL pulse when position==0 and pulse_length!=0.
REQ-036 clock_word SHALL be the alternating 1010... pattern, MSB=1, in any state other than IDLE, and all-zeros in IDLE.
REQ-037 In IDLE and ARMED, revo_word SHALL be zero.

Reset
REQ-038 While reset=1, the block SHALL hold: state IDLE, position 0, period_active 0, revo_word 0, clock_word 0, revo_strobe 0, locked 0, sync_error 0, mismatch_count 0, and the registered sync_in 0.
REQ-039 Reset SHALL override enable, sync and clear_error in the same cycle.

Configuration
REQ-040 Macro REVO_FINE_PHASE_EN defined: with fine_phase=p>0 and 0<pulse_length<=period_active, word at position 0 SHALL be p zeros followed by WIDTH-p ones (MSB first).
REQ-041 Macro REVO_FINE_PHASE_EN defined: positions 1..pulse_length-1 SHALL be all-ones.
REQ-042 Macro REVO_FINE_PHASE_EN defined: the word at position pulse_length SHALL be p ones followed by WIDTH-p zeros.
REQ-043 Macro REVO_FINE_PHASE_EN defined: when the word at position pulse_length falls at wrap, it SHALL merge by OR with the next position-0 word.
REQ-044 Macro REVO_FINE_PHASE_EN undefined: the fine_phase port SHALL exist but be ignored, with behaviour as for p=0.

Verification
REQ-045 Free-run: reset 4 cycles, enable=1, sync_mode=0, period_minus_one=9, pulse_length=2 -> revo_word 8'hFF for 2 of every 10 cycles; revo_strobe period 10; first strobe 2 edges after enable sampled.
REQ-046 Arm and lock: sync_mode=1, sync edge after 5 cycles -> locked=1 next edge; marker 2 edges after the sync edge; aligned edges every 10 cycles -> sync_error stays 0.
REQ-047 Misalignment: in LOCKED, inject a sync edge at position 4 -> sync_error=1, mismatch_count=1, next marker 2 edges later; clear_error -> both 0.
REQ-048 Period change: write period_minus_one=4 mid-revolution -> current revolution completes at length 10, then strobes every 5 cycles.
REQ-049 Boundaries: pulse_length=0 -> revo_word always 0; pulse_length=20 with period 10 -> always 8'hFF; enable dropped mid-marker -> all outputs 0 on next edge.
REQ-050 REVO_FINE_PHASE_EN, p=3, pulse_length=1 -> words 8'h1F then 8'hE0; with the macro undefined -> 8'hFF then 8'h00.
